// File: rtl/rotary_sw.sv
// Rotary selector front end: two-flop sync, per-contact debounce, quadrature detent
// decode and 11-position one-hot selector. Define ROTARY_WRAP_EN to wrap 10<->0.
module rotary_sw #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RESET_POS       = 0
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        enc_a,
  input  logic        enc_b,
  output logic [10:0] rotary_bus,
  output logic [3:0]  pos,
  output logic        step,
  output logic        dir
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       RST_POS  = 4'(RESET_POS);
  localparam logic [10:0]      RST_BUS  = 11'b1 << RESET_POS;
  localparam logic signed [3:0] ACC_MAX = 4'sd4;
  localparam logic signed [3:0] ACC_MIN = -4'sd4;

  // Contact pair is packed as {A, B} throughout
  logic [1:0] w_raw;
  logic [1:0] w_deb;

  assign w_raw = {enc_a, enc_b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_contact
      logic [1:0]       r_sync;
      logic             r_deb;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
          r_sync <= 2'b11;
          r_deb  <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_sync <= {r_sync[0], w_raw[gi]};
          if (r_sync[1] == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_deb <= r_sync[1];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
      end

      assign w_deb[gi] = r_deb;
    end
  endgenerate

  // Position of a contact state along the CW Gray cycle 11->01->00->10
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    case (ab)
      2'b11:   gray_idx = 2'd0;
      2'b01:   gray_idx = 2'd1;
      2'b00:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  logic [1:0]        r_ab_prev;
  logic signed [3:0] r_acc;
  logic [3:0]        r_pos;
  logic [10:0]       r_bus;
  logic              r_step;
  logic              r_dir;

  logic [1:0]        w_delta;
  logic              w_moved;
  logic              w_fwd;
  logic              w_rev;
  logic              w_enter_home;
  logic signed [3:0] w_acc_adj;
  logic              w_cw_detent;
  logic              w_ccw_detent;
  logic [3:0]        w_pos_next;
  logic [10:0]       w_bus_next;
  logic              w_move;

  // A delta of 2 means both contacts changed at once and is ignored
  assign w_delta      = gray_idx(w_deb) - gray_idx(r_ab_prev);
  assign w_moved      = (w_deb != r_ab_prev);
  assign w_fwd        = (w_delta == 2'd1);
  assign w_rev        = (w_delta == 2'd3);
  assign w_enter_home = w_moved && (w_deb == 2'b11);

  always_comb begin
    w_acc_adj = r_acc;
    if (w_fwd && (r_acc != ACC_MAX)) begin
      w_acc_adj = r_acc + 4'sd1;
    end else if (w_rev && (r_acc != ACC_MIN)) begin
      w_acc_adj = r_acc - 4'sd1;
    end
  end

  assign w_cw_detent  = w_enter_home && (w_acc_adj == ACC_MAX);
  assign w_ccw_detent = w_enter_home && (w_acc_adj == ACC_MIN);

  always_comb begin
    w_pos_next = r_pos;
    w_move     = 1'b0;
    if (w_cw_detent) begin
      if (r_pos == 4'd10) begin
`ifdef ROTARY_WRAP_EN
        w_pos_next = 4'd0;
        w_move     = 1'b1;
`endif
      end else begin
        w_pos_next = r_pos + 4'd1;
        w_move     = 1'b1;
      end
    end else if (w_ccw_detent) begin
      if (r_pos == 4'd0) begin
`ifdef ROTARY_WRAP_EN
        w_pos_next = 4'd10;
        w_move     = 1'b1;
`endif
      end else begin
        w_pos_next = r_pos - 4'd1;
        w_move     = 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < 11; gi++) begin : g_bus
      assign w_bus_next[gi] = (w_pos_next == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_ab_prev <= 2'b11;
      r_acc     <= 4'sd0;
      r_pos     <= RST_POS;
      r_bus     <= RST_BUS;
      r_step    <= 1'b0;
      r_dir     <= 1'b1;
    end else begin
      r_ab_prev <= w_deb;
      r_acc     <= w_enter_home ? 4'sd0 : w_acc_adj;
      r_step    <= w_move;
      if (w_move) begin
        r_pos <= w_pos_next;
        r_bus <= w_bus_next;
        r_dir <= w_cw_detent;
      end
    end
  end

  assign rotary_bus = r_bus;
  assign pos        = r_pos;
  assign step       = r_step;
  assign dir        = r_dir;

endmodule

// File: tb/tb_rotary_sw.sv
// Directed bench for rotary_sw: expected steps are queued as detents are driven
// and popped by a monitor whenever the DUT pulses step.
module tb_rotary_sw;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic        enc_a   = 1'b1;
  logic        enc_b   = 1'b1;
  logic [10:0] rotary_bus;
  logic [3:0]  pos;
  logic        step;
  logic        dir;

  int n_tests = 0;
  int n_fail  = 0;

  int   model_pos = 0;
  logic model_dir = 1'b1;
  logic [4:0] exp_q[$];
  logic prev_step = 1'b0;

  rotary_sw #(.DEBOUNCE_CYCLES(4), .RESET_POS(0)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .rotary_bus(rotary_bus),
    .pos       (pos),
    .step      (step),
    .dir       (dir)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every step pulse must match the oldest queued expectation
  always @(posedge clk_sys) begin
    logic [4:0]  e;
    logic [10:0] one_hot;
    #1;
    if (step === 1'b1) begin
      if (prev_step === 1'b1) check("step_width", 32'(prev_step & step), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_step", {27'd0, pos, dir}, 32'h1f);
      end else begin
        e = exp_q.pop_front();
        check("step_pos_dir", {27'd0, pos, dir}, {27'd0, e});
        one_hot = 11'b1 << pos;
        check("step_bus", 32'(rotary_bus), 32'(one_hot));
        $display("[TB] step pos=%0d dir=%0d bus=%b", pos, dir, rotary_bus);
      end
    end
    prev_step = step;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic drive(input logic a, input logic b, input int n);
    enc_a = a;
    enc_b = b;
    tick(n);
  endtask

  task automatic expect_cw();
    if (model_pos == 10) begin
`ifdef ROTARY_WRAP_EN
      model_pos = 0;
      model_dir = 1'b1;
      exp_q.push_back({4'd0, 1'b1});
`endif
    end else begin
      model_pos = model_pos + 1;
      model_dir = 1'b1;
      exp_q.push_back({4'(model_pos), 1'b1});
    end
  endtask

  task automatic expect_ccw();
    if (model_pos == 0) begin
`ifdef ROTARY_WRAP_EN
      model_pos = 10;
      model_dir = 1'b0;
      exp_q.push_back({4'd10, 1'b0});
`endif
    end else begin
      model_pos = model_pos - 1;
      model_dir = 1'b0;
      exp_q.push_back({4'(model_pos), 1'b0});
    end
  endtask

  task automatic cw_detent();
    expect_cw();
    drive(1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, 10);
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
  endtask

  task automatic ccw_detent();
    expect_ccw();
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 10);
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 10);
  endtask

  task automatic check_state(input string tag);
    logic [10:0] one_hot;
    one_hot = 11'b1 << model_pos;
    check({tag, "_pos"}, 32'(pos), 32'(model_pos));
    check({tag, "_bus"}, 32'(rotary_bus), 32'(one_hot));
    check({tag, "_dir"}, 32'(dir), 32'(model_dir));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    $display("[TB] %s pos=%0d bus=%b dir=%0d", tag, pos, rotary_bus, dir);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    model_pos = 0;
    model_dir = 1'b1;
    exp_q.delete();
    tick(2);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("reset_step", 32'(step), 32'd0);
    check_state("reset");

    // Clean CW detent with exact output latency after the final B rise
    expect_cw();
    drive(1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, 10);
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 6);
    check("lat_step_early", 32'(step), 32'd0);
    check("lat_pos_early", 32'(pos), 32'd0);
    tick(1);
    check("lat_step", 32'(step), 32'd1);
    check("lat_dir", 32'(dir), 32'd1);
    check("lat_bus", 32'(rotary_bus), 32'h002);
    tick(3);
    check_state("cw1");

    // Short glitches on A are filtered out
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 3);
      drive(1'b1, 1'b1, 10);
    end
    check_state("glitch");

    // Half detent returns to rest without stepping
    drive(1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, 10);
    drive(1'b0, 1'b1, 10);
    drive(1'b1, 1'b1, 10);
    check_state("half");

    // Walk to 5, then one CCW detent
    for (int i = 0; i < 5; i++) cw_detent();
    check_state("at5");
    ccw_detent();
    check_state("ccw4");

    // Upper boundary
    for (int i = 0; i < 6; i++) cw_detent();
    check_state("at10");
    cw_detent();
    check_state("cw_at10");

    // Lower boundary
    while (model_pos != 0) ccw_detent();
    check_state("at0");
    ccw_detent();
    check_state("ccw_at0");

    // Both contacts flipping together is not a step
    drive(1'b0, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    check_state("both_flip");

    // Reset in the middle of a CW detent discards it
    do_reset();
    cw_detent();
    check_state("pre_rst");
    drive(1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, 10);
    rst = 1'b1;
    tick(3);
    check("rst_mid_pos", 32'(pos), 32'd0);
    check("rst_mid_step", 32'(step), 32'd0);
    rst = 1'b0;
    model_pos = 0;
    model_dir = 1'b1;
    exp_q.delete();
    tick(10);
    drive(1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 10);
    check_state("post_rst");
    cw_detent();
    check_state("after_rst_cw");

    tick(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
